// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter. Stage k applies a shift of 2^k when Cnt bit k is set.
// The pipeline has a valid/ready handshake on both ends and full backpressure.
module shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int LOG2W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [LOG2W-1:0] Cnt,
    input  logic [2:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             out_zero
);

    localparam logic [2:0] OP_SRA = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       op,
                                                  input int               s);
        logic signed [WIDTH-1:0] sd;
        logic        [WIDTH-1:0] r;
        sd = d;
        case (op)
            OP_SRA:  r = sd >>> s;
            OP_SRL:  r = d >> s;
            OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
            OP_SLL:  r = d << s;
            OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
            default: r = d;
        endcase
        return r;
    endfunction

    logic [LOG2W-1:0] vld_p;
    logic [WIDTH-1:0] data_p [LOG2W];
    logic [LOG2W-1:0] cnt_p  [LOG2W];
    logic [2:0]       op_p   [LOG2W];

    logic [LOG2W-1:0] src_vld;
    logic [WIDTH-1:0] src_data [LOG2W];
    logic [LOG2W-1:0] src_cnt  [LOG2W];
    logic [2:0]       src_op   [LOG2W];
    logic [WIDTH-1:0] shf      [LOG2W];
    logic [LOG2W-1:0] adv;

    // Stage inputs: S0 is fed by the ports, every later stage by its predecessor.
    always_comb begin
        src_vld     = '0;
        src_vld[0]  = in_valid;
        src_data[0] = In;
        src_cnt[0]  = Cnt;
        src_op[0]   = Op;
        for (int k = 1; k < LOG2W; k++) begin
            src_vld[k]  = vld_p[k-1];
            src_data[k] = data_p[k-1];
            src_cnt[k]  = cnt_p[k-1];
            src_op[k]   = op_p[k-1];
        end
        for (int k = 0; k < LOG2W; k++) begin
            shf[k] = src_cnt[k][k] ? shift_by(src_data[k], src_op[k], 1 << k) : src_data[k];
        end
    end

    // A stage stalls only when it and every stage after it are full and the sink is not taking.
    // Unrolling the ripple chain this way keeps the stall logic free of self-referencing terms.
    always_comb begin : adv_chain
        logic full_tail;
        full_tail = 1'b1;
        adv       = '0;
        for (int k = LOG2W - 1; k >= 0; k--) begin
            full_tail = full_tail & vld_p[k];
            adv[k]    = out_ready | ~full_tail;
        end
    end

    // Stage registers: bubbles only clear valid, so Out keeps its last real value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int k = 0; k < LOG2W; k++) begin
                data_p[k] <= '0;
                cnt_p[k]  <= '0;
                op_p[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < LOG2W; k++) begin
                if (adv[k]) begin
                    vld_p[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        data_p[k] <= shf[k];
                        cnt_p[k]  <= src_cnt[k];
                        op_p[k]   <= src_op[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_p[LOG2W-1];
    assign Out       = data_p[LOG2W-1];
    assign out_zero  = ~|data_p[LOG2W-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe (WIDTH=16): directed vectors, streaming,
// backpressure, mid-stream reset and a short randomised run against a reference model.
module tb_shifter_pipe;
    localparam int W = 16;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [W-1:0] In, Out;
    logic [L-1:0] Cnt;
    logic [2:0]   Op;

    always #5 clk = ~clk;

    shifter_pipe #(.WIDTH(W), .LOG2W(L)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .In(In), .Cnt(Cnt), .Op(Op),
        .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .out_zero(out_zero)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic [L-1:0] c;
        logic [2:0]   o;
        logic [W-1:0] e;
    } vec_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           n_acc = 0;
    logic [W-1:0] exp_q[$];
    int           pop_cyc[$];
    bit           rand_on = 1'b0;
    bit           bp_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_i(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [L-1:0] c,
                                               input logic [2:0] o);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        case (o)
            3'd0: r = $signed(d) >>> c;
            3'd1: r = d >> c;
            3'd2: begin dd = {d, d} << c; r = dd[2*W-1:W]; end
            3'd3: r = d << c;
            3'd4: begin dd = {d, d} >> c; r = dd[W-1:0]; end
            default: r = d;
        endcase
        return r;
    endfunction

    // Monitor: every output transfer pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %h, required no output (cycle %0d)", Out, cyc);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("out_data", Out, e);
                check("out_zero", W'(out_zero), W'(e == '0));
            end
            pop_cyc.push_back(cyc);
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input vec_t v, input bit push);
        in_valid = 1'b1;
        In       = v.d;
        Cnt      = v.c;
        Op       = v.o;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) exp_q.push_back(v.e);
                acc_cyc = cyc;
                n_acc++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required acceptance");
        in_valid = 1'b0;
    endtask

    vec_t dir[16];
    vec_t bp[6];

    initial begin
        int a0, nb, psz;
        dir[0]  = '{16'h8001, 4'd4,  3'd0, 16'hF800};
        dir[1]  = '{16'h8001, 4'd15, 3'd1, 16'h0001};
        dir[2]  = '{16'h8001, 4'd1,  3'd2, 16'h0003};
        dir[3]  = '{16'h00FF, 4'd8,  3'd3, 16'hFF00};
        dir[4]  = '{16'h0003, 4'd1,  3'd4, 16'h8001};
        dir[5]  = '{16'h1234, 4'd5,  3'd6, 16'h1234};
        dir[6]  = '{16'h8000, 4'd1,  3'd3, 16'h0000};
        dir[7]  = '{16'h8000, 4'd15, 3'd0, 16'hFFFF};
        dir[8]  = '{16'h7FFF, 4'd15, 3'd0, 16'h0000};
        dir[9]  = '{16'hA5C3, 4'd0,  3'd4, 16'hA5C3};
        dir[10] = '{16'hBEEF, 4'd9,  3'd5, 16'hBEEF};
        dir[11] = '{16'hCAFE, 4'd3,  3'd7, 16'hCAFE};
        dir[12] = '{16'h1234, 4'd4,  3'd2, 16'h2341};
        dir[13] = '{16'h1234, 4'd4,  3'd4, 16'h4123};
        dir[14] = '{16'hF0F0, 4'd3,  3'd1, 16'h1E1E};
        dir[15] = '{16'h0F0F, 4'd5,  3'd3, 16'hE1E0};
        for (int i = 0; i < 6; i++) bp[i] = '{16'h0101 * (i + 1), 4'd0, 3'd1, 16'h0101 * (i + 1)};

        rst = 1'b1; in_valid = 1'b0; In = '0; Cnt = '0; Op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), 16'h0);
        check("rst_out", Out, 16'h0000);
        check("rst_out_zero", W'(out_zero), 16'h1);
        check("rst_in_ready", W'(in_ready), 16'h1);
        @(posedge clk);
        #1;

        // Latency of a lone item on an empty pipeline.
        send(dir[0], 1'b1);
        a0 = acc_cyc;
        repeat (8) @(posedge clk);
        #1;
        if (pop_cyc.size() == 0) check_i("latency_timeout", 0, 1);
        else check_i("latency", pop_cyc[0] - a0, L);

        // Remaining directed vectors, then all 16 again... first 8 as a stream.
        for (int i = 1; i < 16; i++) send(dir[i], 1'b1);
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            send(dir[i], 1'b1);
            if (i == 0) a0 = acc_cyc;
        end
        check_i("stream_accept_span", acc_cyc - a0, 7);
        repeat (8) @(posedge clk);
        #1;
        psz = pop_cyc.size();
        if (psz < 8) check_i("stream_out_count", psz, 8);
        else check_i("stream_out_span", pop_cyc[psz-1] - pop_cyc[psz-8], 7);

        // Backpressure: sink stalled while six items are offered.
        out_ready = 1'b0;
        nb = n_acc;
        fork
            begin
                for (int i = 0; i < 6; i++) send(bp[i], 1'b1);
                bp_done = 1'b1;
            end
        join_none
        repeat (10) @(posedge clk);
        #1;
        check_i("bp_accepted", n_acc - nb, L);
        check("bp_in_ready", W'(in_ready), 16'h0);
        check("bp_out_valid", W'(out_valid), 16'h1);
        check("bp_out_hold0", Out, bp[0].e);
        repeat (3) @(posedge clk);
        #1;
        check("bp_out_hold1", Out, bp[0].e);
        out_ready = 1'b1;
        for (int t = 0; t < 50 && !bp_done; t++) @(posedge clk);
        #1;
        check("bp_sender_done", W'(bp_done), 16'h1);
        repeat (8) @(posedge clk);
        #1;
        check_i("bp_drained", exp_q.size(), 0);

        // Reset with three items in flight; none of them may surface.
        for (int i = 0; i < 3; i++) send(dir[12 + i], 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_out_valid", W'(out_valid), 16'h0);
        check("mid_rst_in_ready", W'(in_ready), 16'h1);
        repeat (8) @(posedge clk);
        #1;
        psz = pop_cyc.size();
        send(dir[3], 1'b1);
        a0 = acc_cyc;
        repeat (8) @(posedge clk);
        #1;
        if (pop_cyc.size() != psz + 1) check_i("post_rst_out_count", pop_cyc.size() - psz, 1);
        else check_i("post_rst_latency", pop_cyc[psz] - a0, L);

        // Randomised traffic with a toggling sink.
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    if (rand_on) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v.d = W'($urandom);
            v.c = L'($urandom_range(0, W - 1));
            v.o = 3'($urandom_range(0, 7));
            v.e = ref_shift(v.d, v.c, v.o);
            send(v, 1'b1);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_on = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check_i("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
